// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared types and constants for the MD5 message padder
package md5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_LEN,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    // What the padder does once the cruncher finishes the chunk in flight
    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_PAD,
        PEND_ZERO,
        PEND_FINAL
    } pend_t;

    localparam logic [7:0] PAD_BYTE = 8'h80;
    localparam logic [5:0] LEN_POS  = 6'd56;

endpackage

// File: rtl/md5_chunk_buf.sv
// rtl/md5_chunk_buf.sv - 16x32 byte-writable chunk buffer with combinational read
module md5_chunk_buf (
    input  logic        clk,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data
);

    logic [15:0][31:0] mem_q;
    logic [15:0][31:0] mem_d;

    // Merge enabled byte lanes of the write into the addressed word
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_d[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    // Storage is deliberately not reset; every chunk rewrites all 64 bytes
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/md5_msg_padder.sv
// rtl/md5_msg_padder.sv - MD5 padding front end; MD5_PADDER_WORD_PAD_EN selects word-wide zero fill
module md5_msg_padder
    import md5_pkg::*;
#(
    parameter int CNT_W = 61
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_keep,
    input  logic        in_last,
    output logic        crunch_reset,
    output logic        crunch_start,
    input  logic        crunch_done,
    input  logic [3:0]  gaddr,
    output logic [31:0] mdata,
    output logic        msg_done
);

    state_t           state_q, state_d;
    pend_t            pend_q, pend_d;
    logic [5:0]       p_q, p_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pad80_q, pad80_d;
    logic             len_hi_q, len_hi_d;
    logic             crunch_reset_q, crunch_reset_d;

    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    logic [63:0]      bitlen;
    logic             accept;
    logic [5:0]       base_p;
    logic [CNT_W-1:0] base_cnt;
    logic [5:0]       pad_p_nx;

    // Message bit length, wrapped to 64 bits
    always_comb begin
        bitlen = 64'({count_q, 3'b000});
    end

    // Next-state, buffer write port and handshake outputs
    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        p_d            = p_q;
        count_d        = count_q;
        pad80_d        = pad80_q;
        len_hi_d       = len_hi_q;
        crunch_reset_d = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = p_q[5:2];
        wr_be          = 4'b0000;
        wr_data        = 32'h0;
        in_ready       = 1'b0;
        crunch_start   = 1'b0;
        msg_done       = 1'b0;
        accept         = 1'b0;
        base_p         = p_q;
        base_cnt       = count_q;
        pad_p_nx       = p_q;

        case (state_q)
            ST_IDLE, ST_FILL: begin
                in_ready = !reset;
                accept   = in_valid && !reset;
                if (state_q == ST_IDLE) begin
                    base_p   = 6'd0;
                    base_cnt = '0;
                end
                if (accept) begin
                    if (state_q == ST_IDLE) begin
                        crunch_reset_d = 1'b1;
                        pend_d         = PEND_NONE;
                    end
                    state_d = ST_FILL;
                    p_d     = base_p;
                    count_d = base_cnt;
                    if (in_keep) begin
                        wr_en   = 1'b1;
                        wr_addr = base_p[5:2];
                        wr_be   = 4'b0001 << base_p[1:0];
                        wr_data = {4{in_data}};
                        p_d     = base_p + 6'd1;
                        count_d = base_cnt + CNT_W'(1);
                        if (base_p == 6'd63) begin
                            state_d = ST_START;
                            pend_d  = in_last ? PEND_PAD : PEND_NONE;
                            pad80_d = 1'b1;
                        end else if (in_last) begin
                            state_d = ST_PAD;
                            pad80_d = 1'b1;
                        end
                    end else if (in_last) begin
                        state_d = ST_PAD;
                        pad80_d = 1'b1;
                    end
                end
            end

            ST_PAD: begin
                wr_en   = 1'b1;
                wr_addr = p_q[5:2];
                wr_data = pad80_q ? (32'(PAD_BYTE) << {p_q[1:0], 3'b000}) : 32'h0;
`ifdef MD5_PADDER_WORD_PAD_EN
                wr_be    = 4'b1111 << p_q[1:0];
                pad_p_nx = {p_q[5:2] + 4'd1, 2'b00};
`else
                wr_be    = 4'b0001 << p_q[1:0];
                pad_p_nx = p_q + 6'd1;
`endif
                pad80_d = 1'b0;
                p_d     = pad_p_nx;
                if (pad_p_nx == LEN_POS) begin
                    state_d  = ST_LEN;
                    len_hi_d = 1'b0;
                end else if (pad_p_nx == 6'd0) begin
                    state_d = ST_START;
                    pend_d  = PEND_ZERO;
                end
            end

            ST_LEN: begin
                wr_en   = 1'b1;
                wr_be   = 4'b1111;
                wr_addr = len_hi_q ? 4'd15 : 4'd14;
                wr_data = len_hi_q ? bitlen[63:32] : bitlen[31:0];
                if (len_hi_q) begin
                    state_d = ST_START;
                    pend_d  = PEND_FINAL;
                end else begin
                    len_hi_d = 1'b1;
                end
            end

            ST_START: begin
                crunch_start = 1'b1;
                state_d      = ST_WAIT;
            end

            ST_WAIT: begin
                if (crunch_done) begin
                    p_d    = 6'd0;
                    pend_d = PEND_NONE;
                    case (pend_q)
                        PEND_NONE: state_d = ST_FILL;
                        PEND_PAD: begin
                            state_d = ST_PAD;
                            pad80_d = 1'b1;
                        end
                        PEND_ZERO: begin
                            state_d = ST_PAD;
                            pad80_d = 1'b0;
                        end
                        default: state_d = ST_DONE;
                    endcase
                end
            end

            ST_DONE: begin
                msg_done = 1'b1;
                state_d  = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset abandons any message in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pend_q         <= PEND_NONE;
            p_q            <= 6'd0;
            count_q        <= '0;
            pad80_q        <= 1'b0;
            len_hi_q       <= 1'b0;
            crunch_reset_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            p_q            <= p_d;
            count_q        <= count_d;
            pad80_q        <= pad80_d;
            len_hi_q       <= len_hi_d;
            crunch_reset_q <= crunch_reset_d;
        end
    end

    assign crunch_reset = crunch_reset_q;

    md5_chunk_buf u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .rd_addr (gaddr),
        .rd_data (mdata)
    );

endmodule

// File: tb/tb_md5_msg_padder.sv
// tb/tb_md5_msg_padder.sv - self-checking bench for md5_msg_padder
module tb_md5_msg_padder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_keep;
    logic        in_last;
    logic        crunch_reset;
    logic        crunch_start;
    logic        crunch_done;
    logic [3:0]  gaddr;
    logic [31:0] mdata;
    logic        msg_done;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int n_creset = 0;
    int n_start = 0;
    int n_done = 0;
    int creset_cyc = 0;
    int first_start_cyc = -1;
    int last_start_cyc = 0;
    int acc_cyc = 0;
    int wait_viol = 0;
    logic [31:0] got_q[$];

    always #50 clk = ~clk;

    md5_msg_padder dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_keep      (in_keep),
        .in_last      (in_last),
        .crunch_reset (crunch_reset),
        .crunch_start (crunch_start),
        .crunch_done  (crunch_done),
        .gaddr        (gaddr),
        .mdata        (mdata),
        .msg_done     (msg_done)
    );

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (crunch_reset === 1'b1) begin
            n_creset        <= n_creset + 1;
            creset_cyc      <= cyc;
            first_start_cyc <= -1;
        end
        if (crunch_start === 1'b1) begin
            n_start        <= n_start + 1;
            last_start_cyc <= cyc;
            if (first_start_cyc < 0) first_start_cyc <= cyc;
        end
        if (msg_done === 1'b1) n_done <= n_done + 1;
    end

    // Cruncher stand-in: reads the whole chunk, holds done low a random while
    initial begin
        crunch_done = 1'b1;
        gaddr       = 4'd0;
        forever begin
            @(negedge clk);
            if (crunch_start === 1'b1) begin
                @(posedge clk);
                #1 crunch_done = 1'b0;
                for (int w = 0; w < 16; w++) begin
                    gaddr = w[3:0];
                    #1 got_q.push_back(mdata);
                end
                repeat ($urandom_range(1, 6)) begin
                    @(negedge clk);
                    if (in_ready !== 1'b0) wait_viol++;
                end
                crunch_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic k, input logic l);
        int   wt;
        logic rdy;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        wt       = 0;
        rdy      = 1'b0;
        while (wt < 500) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) break;
            wt++;
        end
        in_valid = 1'b0;
        in_keep  = 1'b0;
        in_last  = 1'b0;
        acc_cyc  = cyc;
        if (rdy !== 1'b1) chk("accept_timeout", {63'd0, rdy}, 64'd1);
    endtask

    // Sends one message, then checks chunks against the padding rules
    task automatic run_msg(input string tag, input int len, input bit abc, input bit trail,
                           output int pad_lat);
        logic [7:0]  msg[$];
        logic [7:0]  pb[$];
        logic [31:0] ew[$];
        logic [63:0] bl;
        int base, done0, creset0, viol0, wt;
        for (int i = 0; i < len; i++) begin
            if (abc) msg.push_back(8'h61 + 8'(i));
            else     msg.push_back(8'($urandom_range(0, 255)));
        end
        base    = got_q.size();
        done0   = n_done;
        creset0 = n_creset;
        viol0   = wait_viol;
        if (len == 0) begin
            drive_beat(8'h00, 1'b0, 1'b1);
        end else begin
            for (int i = 0; i < len; i++) drive_beat(msg[i], 1'b1, (i == len - 1) && !trail);
            if (trail) drive_beat(8'h00, 1'b0, 1'b1);
        end
        wt = 0;
        while (n_done == done0 && wt < 5000) begin
            @(posedge clk);
            #1;
            wt++;
        end
        repeat (3) @(posedge clk);
        #1;
        pad_lat = last_start_cyc - acc_cyc;

        pb = msg;
        pb.push_back(8'h80);
        while (pb.size() % 64 != 56) pb.push_back(8'h00);
        bl = 64'(len) * 64'd8;
        for (int i = 0; i < 8; i++) pb.push_back(bl[8*i +: 8]);
        for (int i = 0; i < pb.size() / 4; i++)
            ew.push_back({pb[4*i+3], pb[4*i+2], pb[4*i+1], pb[4*i]});

        chk({tag, "_msg_done"}, 64'(n_done - done0), 64'd1);
        chk({tag, "_crunch_reset"}, 64'(n_creset - creset0), 64'd1);
        chk({tag, "_reset_lead"}, {63'd0, (first_start_cyc - creset_cyc) >= 3}, 64'd1);
        chk({tag, "_wait_ready"}, 64'(wait_viol - viol0), 64'd0);
        chk({tag, "_chunk_words"}, 64'(got_q.size() - base), 64'(ew.size()));
        for (int i = 0; i < ew.size() && base + i < got_q.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), 64'(got_q[base + i]), 64'(ew[i]));
    endtask

    initial begin
        int lat;
        int exp_lat;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_keep  = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_reset_outs", {61'd0, crunch_start, crunch_reset, msg_done}, 64'd0);
        @(posedge clk);
        #1;

        run_msg("empty", 0, 1'b0, 1'b0, lat);
        run_msg("abc", 3, 1'b1, 1'b0, lat);
`ifdef MD5_PADDER_WORD_PAD_EN
        exp_lat = 14 + 2;
`else
        exp_lat = 53 + 2;
`endif
        chk("abc_pad_cycles", 64'(lat), 64'(exp_lat));
        run_msg("len55", 55, 1'b0, 1'b0, lat);
        run_msg("len56", 56, 1'b0, 1'b0, lat);
        run_msg("len64", 64, 1'b0, 1'b0, lat);
        run_msg("len64_trail", 64, 1'b0, 1'b1, lat);
        run_msg("len120", 120, 1'b0, 1'b0, lat);

        for (int i = 0; i < 20; i++) drive_beat(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset_after_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        run_msg("abc_after_reset", 3, 1'b1, 1'b0, lat);

        for (int r = 0; r < 5; r++)
            run_msg($sformatf("rand%0d", r), int'($urandom_range(0, 140)), 1'b0,
                    1'($urandom_range(0, 1)), lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md5_msg_padder.md
# md5_msg_padder

Message-side front end for `md5_chunk_cruncher`. Accepts a message as a byte stream and applies MD5 padding: `0x80`, zero fill, then the 64-bit little-endian bit length. It assembles each 512-bit chunk in a 16-word buffer, serves the cruncher's `gaddr` reads, and sequences start/done per chunk. It pulses `msg_done` once the final chunk has been crunched, at which point the cruncher's `digest` is valid.

## Interface
- `CNT_W`, default 61: byte counter width. Bit length is `{count, 3'b000}`, zero-extended or truncated to 64 bits, mod 2^64.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: padder accepts a beat this cycle.
- `in_data` in 8: message byte.
- `in_keep` in 1: beat carries a byte. `0` is legal only with `in_last`, for an empty message or a trailing empty beat.
- `in_last` in 1: final beat of the message.
- `crunch_reset` out 1: one-cycle pulse that reinitialises the cruncher's a0..d0.
- `crunch_start` out 1: one-cycle chunk start pulse.
- `crunch_done` in 1: cruncher `done` level.
- `gaddr` in 4: word index requested by the cruncher.
- `mdata` out 32: `buf[gaddr]`, combinational.
- `msg_done` out 1: one-cycle pulse, digest valid.

## Operation
- Buffer: 16 × 32-bit words. Chunk byte position `p` (0..63) maps to `buf[p>>2][8*(p%4)+:8]` (little-endian).
- States:
  - IDLE: `in_ready=1`. An accepted beat moves to FILL, registers `crunch_reset`, clears `count`, sets `p=0`, and is processed as in FILL.
  - FILL: `in_ready=1`. A beat with `keep` writes the byte at `p`, increments `p` and `count`.
    - `p` wrapping 63→0 → START. If `last` was also set, `pend=PAD` (padding resumes after this chunk).
    - `last` without a wrap → PAD.
  - PAD: first cycle writes `0x80` at `p`, then writes zero bytes.
    - After each write: if `p==56` → LEN.
    - If `p` wraps to 0 → START with `pend=ZERO` (next chunk zero-fills from 0 to 56).
  - LEN: cycle 1 writes `buf[14]=bitlen[31:0]`; cycle 2 writes `buf[15]=bitlen[63:32]`. Then → START with `pend=FINAL`.
  - START: `crunch_start=1` for exactly one cycle → WAIT.
  - WAIT: buffer frozen, `in_ready=0`. On `crunch_done=1`, branch on `pend`:
    - NONE → FILL with `p=0`.
    - PAD → PAD at `p=0`, with the `0x80` still pending.
    - ZERO → PAD at `p=0` in zero-only mode.
    - FINAL → DONE.
  - DONE: `msg_done=1` for one cycle → IDLE.
- `0x80` is written exactly once per message. Zero-only mode skips it.
- Simultaneous `crunch_done` and input: in WAIT, input is never accepted.
- Reset mid-message: abandons the message; state → IDLE, `pend=NONE`. Buffer contents are not reset.

## Timing
- Reset values: `in_ready=0` while `reset` is asserted and 1 in the first cycle after. `crunch_start`, `crunch_reset`, `msg_done` are 0 after reset.
- One byte per accepted cycle in FILL.
- Padding cost without the macro: one cycle per padding byte.
- START→WAIT: the cruncher drops `done` the cycle after it samples start, so WAIT first samples `crunch_done` one cycle after START. The stale `done=1` from before start is never observed.
- `mdata` has zero latency from `gaddr`.
- `crunch_reset` precedes the first `crunch_start` by at least 3 cycles.

## Configuration
- `MD5_PADDER_WORD_PAD_EN`
  - Defined: the `0x80` cycle also zeroes the remaining bytes of its word. Subsequent PAD cycles zero one whole word each, until `p==56` or wrap.
  - Undefined: one byte per cycle.
  - Buffer contents, chunk count and digest are identical either way; only cycle counts differ.

## Structure
- Package `md5_pkg`:
  - state enum;
  - `pend` enum {NONE, PAD, ZERO, FINAL};
  - constants `PAD_BYTE=8'h80` and `LEN_POS=6'd56`.
- One sub-module `md5_chunk_buf`: 16×32 byte/word-writable register file with combinational read port.

## Test plan
- Empty message (single beat, `keep=0`, `last=1`) -> one chunk: `buf[0]=0x00000080`, words 1–15 = 0. `msg_done` once; digest bytes `d41d8cd98f00b204e9800998ecf8427e`.
- "abc" -> one chunk: `buf[0]=0x80636261`, `buf[14]=0x18`, `buf[15]=0`. Digest `900150983cd24fb0d6963f7d28e17f72`.
- 55 bytes -> one chunk with `0x80` at byte 55 and `buf[14]=0x1B8`. 56 bytes -> two `crunch_start` pulses; second chunk all zero except `buf[14]=0x1C0`.
- 64 bytes with `last` on byte 63 -> two chunks; second has `buf[0]=0x80` and `buf[14]=0x200`. `in_ready=0` throughout each WAIT.
- Reset asserted mid-FILL after 20 bytes, then "abc" -> `crunch_reset` pulses again and the "abc" digest is correct.
- With `MD5_PADDER_WORD_PAD_EN`, "abc" -> PAD lasts 14 cycles instead of 53; buffer contents are identical.
